// File: rtl/adc_buffer_reader_if.sv
// Sample stream from the buffer reader toward the host link (valid/ready, with last marker).
interface adc_buffer_reader_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/adc_buffer_reader.sv
// Streams a circular window of the ADC sample buffer; a 2-entry skid FIFO absorbs the
// buffer's 1-cycle read latency so backpressure never drops or repeats a sample.
module adc_buffer_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [ADDR_WIDTH:0]   length_i,
   input  logic                  abort_i,
   output logic [ADDR_WIDTH-1:0] buf_read_addr_o,
   input  logic [DATA_WIDTH-1:0] buf_data_i,
   adc_buffer_reader_if.master   m_if,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_issue_q, rem_issue_d;
   logic [ADDR_WIDTH:0]   rem_send_q, rem_send_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            count_q, count_d;
   logic                  done_q, done_d;

   logic                  pop;
   logic                  issue;
   logic [2:0]            occ;

   assign pop   = (count_q != 2'd0) && m_if.m_ready;
   // Occupancy the FIFO will have once this cycle's pop and arriving sample settle.
   assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
   assign issue = (state_q == STREAM) && (rem_issue_q != '0) && (occ < 3'd2);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_issue_d = rem_issue_q;
      rem_send_d  = rem_send_q;
      inflight_d  = 1'b0;
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (length_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = STREAM;
                  addr_d      = start_addr_i;
                  rem_issue_d = length_i;
                  rem_send_d  = length_i;
               end
            end
         end
         default: begin
            if (abort_i) begin
               state_d  = IDLE;
               count_d  = 2'd0;
               rd_ptr_d = 1'b0;
               wr_ptr_d = 1'b0;
            end else begin
               inflight_d = issue;
               if (issue) begin
                  addr_d      = addr_q + ADDR_ONE;
                  rem_issue_d = rem_issue_q - CNT_ONE;
                  if (rem_issue_q == CNT_ONE) state_d = FLUSH;
               end
               if (inflight_q) begin
                  mem_d[wr_ptr_q] = buf_data_i;
                  wr_ptr_d        = ~wr_ptr_q;
               end
               if (pop) begin
                  rd_ptr_d   = ~rd_ptr_q;
                  rem_send_d = rem_send_q - CNT_ONE;
                  if (rem_send_q == CNT_ONE) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
               count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_issue_q <= '0;
         rem_send_q  <= '0;
         inflight_q  <= 1'b0;
         mem_q       <= '{default: '0};
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_issue_q <= rem_issue_d;
         rem_send_q  <= rem_send_d;
         inflight_q  <= inflight_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

   assign buf_read_addr_o = addr_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = done_q;
   assign m_if.m_valid    = (count_q != 2'd0);
   assign m_if.m_data     = m_if.m_valid ? mem_q[rd_ptr_q] : '0;
   // The FIFO head is always the next sample to send, so last is a pure count test.
   assign m_if.m_last     = m_if.m_valid && (rem_send_q == CNT_ONE);

endmodule
